mem_ctrl: RTL and testbench

//  Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage (load/store).

---
 rtl/mem_ctrl_if.sv | 32 +++
 rtl/mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the IF/MEM pipeline stages, the RAM port and mem_ctrl.
// The slave view belongs to the controller; the master view drives it.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              stall_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, stall_req, ram_addr, ram_wr, ram_dout
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, stall_req, ram_addr, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter: round-robin between instruction fetch and load/store,
// splitting each access into 1/2/4 byte cycles and assembling reads little-endian.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;          // 1 = MEM stage owns the port
    logic              last_grant_reg, last_grant_next;
    logic [2:0]        len_reg, len_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic              ram_wr_reg, ram_wr_next;
    logic [7:0]        ram_dout_reg, ram_dout_next;

    logic              grant_mem;
    logic [2:0]        mem_len;
    logic [2:0]        cnt_inc;
    logic [3:0]        lane_hit;

    // RAM data trails the address by one cycle, so lane k loads when the counter reads k+1.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_hit[gi] = (state_reg == RD) && (cnt_reg == 3'(gi + 1));
    end

    assign grant_mem = bus.mem_req & (~bus.if_req | ~last_grant_reg);
    assign cnt_inc   = cnt_reg + 3'd1;

    always_comb begin
        case (bus.mem_size)
            2'd0:    mem_len = 3'd1;
            2'd1:    mem_len = 3'd2;
            default: mem_len = 3'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b0;
            len_reg        <= '0;
            cnt_reg        <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            ram_addr_reg   <= '0;
            ram_wr_reg     <= 1'b0;
            ram_dout_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            len_reg        <= len_next;
            cnt_reg        <= cnt_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            ram_addr_reg   <= ram_addr_next;
            ram_wr_reg     <= ram_wr_next;
            ram_dout_reg   <= ram_dout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        len_next        = len_reg;
        cnt_next        = cnt_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        ram_addr_next   = ram_addr_reg;
        ram_wr_next     = 1'b0;
        ram_dout_next   = ram_dout_reg;

        for (int i = 0; i < 4; i++) begin
            if (lane_hit[i]) rdata_next[8*i +: 8] = bus.ram_din;
        end

        case (state_reg)
            IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    owner_next    = grant_mem;
                    len_next      = grant_mem ? mem_len : 3'd4;
                    cnt_next      = '0;
                    rdata_next    = '0;
                    ram_addr_next = grant_mem ? ADDR_W'(bus.mem_addr) : ADDR_W'(bus.if_addr);
                    if (grant_mem && bus.mem_we) begin
                        // Byte 0 goes out with the first address; the rest shift down behind it.
                        ram_wr_next   = 1'b1;
                        ram_dout_next = bus.mem_wdata[7:0];
                        wdata_next    = {8'h00, bus.mem_wdata[31:8]};
                        state_next    = WR;
                    end else begin
                        wdata_next    = '0;
                        state_next    = RD;
                    end
                end
            end
            WR: begin
                if (cnt_inc < len_reg) begin
                    ram_addr_next = ram_addr_reg + ADDR_W'(1);
                    ram_wr_next   = 1'b1;
                    ram_dout_next = wdata_reg[7:0];
                    wdata_next    = {8'h00, wdata_reg[31:8]};
                    cnt_next      = cnt_inc;
                end else begin
                    state_next    = DONE;
                end
            end
            RD: begin
                if (cnt_reg == len_reg) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc < len_reg) ram_addr_next = ram_addr_reg + ADDR_W'(1);
                end
            end
            DONE: begin
                last_grant_next = owner_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.if_done   = (state_reg == DONE) & ~owner_reg;
    assign bus.mem_done  = (state_reg == DONE) &  owner_reg;
    assign bus.if_data   = bus.if_done  ? rdata_reg : '0;
    assign bus.mem_rdata = bus.mem_done ? rdata_reg : '0;
    assign bus.stall_req = (bus.if_req & ~bus.if_done) | (bus.mem_req & ~bus.mem_done);
    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_wr    = ram_wr_reg;
    assign bus.ram_dout  = ram_dout_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table plus hand sequences for arbitration, wrap and reset abort,
// with a done/write scoreboard fed at stimulus time and drained by a negedge monitor.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32)) bus();
    mem_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          is_mem;
        bit          we;
        bit [1:0]    size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [7:0] ram [0:65535];

    bit          exp_own[$];
    logic [31:0] exp_dat[$];
    logic [31:0] exp_wa[$];
    logic [7:0]  exp_wb[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.ram_din <= ram[bus.ram_addr[15:0]];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void flag(string name, logic [31:0] act);
        n_total++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endfunction

    function automatic int nbytes(bit [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    always @(negedge clk) begin
        if (bus.if_done === 1'b1 || bus.mem_done === 1'b1) begin
            if (exp_own.size() == 0) begin
                flag("unexpected_done", {30'd0, bus.mem_done, bus.if_done});
            end else begin
                automatic bit          own = exp_own.pop_front();
                automatic logic [31:0] dat = exp_dat.pop_front();
                chk("done_owner", {31'd0, bus.mem_done}, {31'd0, own});
                chk("done_excl", {31'd0, bus.if_done & bus.mem_done}, 32'd0);
                chk("done_data", own ? bus.mem_rdata : bus.if_data, dat);
                chk("idle_data", own ? bus.if_data : bus.mem_rdata, 32'd0);
            end
        end
        if (bus.ram_wr === 1'b1) begin
            if (exp_wa.size() == 0) begin
                flag("unexpected_write", bus.ram_addr);
            end else begin
                automatic logic [31:0] a = exp_wa.pop_front();
                automatic logic [7:0]  d = exp_wb.pop_front();
                chk("wr_addr", bus.ram_addr, a);
                chk("wr_data", {24'd0, bus.ram_dout}, {24'd0, d});
            end
        end
    end

    task automatic wait_done(output int c);
        c = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.if_done === 1'b1 || bus.mem_done === 1'b1) begin
                c = cyc;
                return;
            end
        end
    endtask

    task automatic run_txn(input vec_t v);
        int c0, cd;
        exp_own.push_back(v.is_mem);
        exp_dat.push_back(v.exp);
        if (v.is_mem && v.we) begin
            for (int k = 0; k < nbytes(v.size); k++) begin
                exp_wa.push_back(v.addr + 32'(k));
                exp_wb.push_back(v.wdata[8*k +: 8]);
            end
        end
        if (v.is_mem) begin
            bus.mem_we = v.we; bus.mem_size = v.size;
            bus.mem_addr = v.addr; bus.mem_wdata = v.wdata; bus.mem_req = 1'b1;
        end else begin
            bus.if_addr = v.addr; bus.if_req = 1'b1;
        end
        c0 = cyc;
        wait_done(cd);
        chk("latency", 32'(cd - c0), 32'(v.lat));
        $display("txn %s we=%0d size=%0d addr=%h wdata=%h lat=%0d", v.is_mem ? "MEM" : "IF ",
                 v.we, v.size, v.addr, v.wdata, cd - c0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        bus.mem_req = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        int c0, cd;
        int arb_cyc[4];
        bit arb_own[4];

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0020] = 8'h34; ram[16'h0021] = 8'h12; ram[16'h0022] = 8'h56; ram[16'h0023] = 8'h78;
        ram[16'h0025] = 8'h9A;
        ram[16'h3001] = 8'h44; ram[16'h3002] = 8'h33; ram[16'h3003] = 8'h22; ram[16'h3004] = 8'h11;
        ram[16'h003F] = 8'h01; ram[16'h0040] = 8'h02; ram[16'h0041] = 8'h03; ram[16'h0042] = 8'h04;
        ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB; ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;

        tbl[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          32'h0000_0513, 6};
        tbl[1] = '{1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0,          2};
        tbl[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_0020, 32'h0,          32'h0000_1234, 4};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 32'h0000_0021, 32'h0,          32'h0000_0012, 3};
        tbl[4] = '{1'b1, 1'b1, 2'd2, 32'h0000_3001, 32'h1122_3344, 32'h0,          5};
        tbl[5] = '{1'b1, 1'b0, 2'd3, 32'h0000_3001, 32'h0,          32'h1122_3344, 6};
        tbl[6] = '{1'b1, 1'b1, 2'd1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,          3};
        tbl[7] = '{1'b1, 1'b0, 2'd2, 32'h0000_003F, 32'h0,          32'h0403_0201, 6};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 32'h0000_0022, 32'h0,          32'h9A00_7856, 6};
        tbl[9] = '{1'b1, 1'b0, 2'd0, 32'h0000_3004, 32'h0,          32'h0000_0011, 3};

        bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        bus.mem_size = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_addr", bus.ram_addr, 32'd0);
        chk("reset_wr", {31'd0, bus.ram_wr}, 32'd0);
        chk("reset_dout", {24'd0, bus.ram_dout}, 32'd0);
        chk("reset_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("reset_done", {30'd0, bus.mem_done, bus.if_done}, 32'd0);
        @(posedge clk); #1;

        // Both requesting from reset: MEM first, then strict alternation.
        arb_cyc = '{4, 11, 16, 23};
        arb_own = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            exp_own.push_back(arb_own[i]);
            exp_dat.push_back(arb_own[i] ? 32'h0000_1234 : 32'h0000_0513);
        end
        bus.if_addr = 32'h100; bus.mem_addr = 32'h20; bus.mem_size = 2'd1; bus.mem_we = 1'b0;
        bus.if_req = 1'b1; bus.mem_req = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_done(cd);
            chk("arb_cycle", 32'(cd - c0), 32'(arb_cyc[i]));
            chk("arb_owner", {31'd0, bus.mem_done}, {31'd0, arb_own[i]});
            $display("txn arb %0d owner=%s done_at=+%0d", i, bus.mem_done ? "MEM" : "IF ", cd - c0);
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.mem_req = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // IF fetch across the top of the address space, with the address disturbed after grant.
        exp_own.push_back(1'b0);
        exp_dat.push_back(32'hDDCC_BBAA);
        bus.if_addr = 32'hFFFF_FFFE; bus.if_req = 1'b1;
        c0 = cyc;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) chk("wrap_addr", bus.ram_addr, 32'hFFFF_FFFE + 32'(k - 1));
            chk("wrap_stall", {31'd0, bus.stall_req}, (k < 6) ? 32'd1 : 32'd0);
            if (k == 1) bus.if_addr = 32'h1234_5678;
        end
        chk("wrap_done", {31'd0, bus.if_done}, 32'd1);
        $display("txn IF  wrap addr=fffffffe done_at=+%0d", cyc - c0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        // Store aborted by reset after its second byte: two writes, no done pulse.
        exp_wa.push_back(32'h500); exp_wb.push_back(8'h04);
        exp_wa.push_back(32'h501); exp_wb.push_back(8'h03);
        bus.mem_we = 1'b1; bus.mem_size = 2'd2; bus.mem_addr = 32'h500; bus.mem_wdata = 32'h0102_0304;
        bus.mem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; bus.mem_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_wr", {31'd0, bus.ram_wr}, 32'd0);
        chk("abort_addr", bus.ram_addr, 32'd0);
        chk("abort_stall", {31'd0, bus.stall_req}, 32'd0);
        $display("txn MEM SW @00000500 aborted by reset");
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        run_txn(tbl[0]);

        chk("sb_done_left", 32'(exp_own.size()), 32'd0);
        chk("sb_write_left", 32'(exp_wa.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
